// File: rtl/multicycle_ctrl_pkg.sv
// Shared processor definitions: FSM state codes, opcode constants and
// opcode class helpers used by the multicycle control unit.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_BAD    = 3'd7
    } state_t;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_ALU_LO = 4'h0;
    localparam logic [OPC_W-1:0] OP_ALU_HI = 4'h7;
    localparam logic [OPC_W-1:0] OP_LOAD   = 4'h8;
    localparam logic [OPC_W-1:0] OP_STORE  = 4'h9;
    localparam logic [OPC_W-1:0] OP_BRANCH = 4'hA;
    localparam logic [OPC_W-1:0] OP_JUMP   = 4'hB;
    localparam logic [OPC_W-1:0] OP_ILL_LO = 4'hC;
    localparam logic [OPC_W-1:0] OP_ILL_HI = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

    function automatic logic is_mem(input logic [OPC_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_flow(input logic [OPC_W-1:0] op);
        return (op == OP_BRANCH) || (op == OP_JUMP);
    endfunction

    function automatic logic is_illegal(input logic [OPC_W-1:0] op);
        return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath strobes and counts retired instructions.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt_req,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    output logic [2:0]      state,
    output logic            mem_req,
    output logic            mem_we,
    output logic            ir_we,
    output logic            pc_we,
    output logic            reg_we,
    output logic            busy,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    state_t            r_state;
    state_t            w_next;
    logic [OPC_W-1:0]  r_op;
    logic [OPC_W-1:0]  w_op_in;
    logic              r_halt_pend;
    logic              r_illegal;
    logic [CNTW-1:0]   r_count;
    logic              w_boundary;
    logic              w_retire;
    logic              w_set_ill;
    logic              w_idle_like;
    state_t            w_bound_tgt;

    assign w_op_in     = OPC_W'(opcode);
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_HALT);
    // A halt request seen mid-instruction is remembered until the next boundary.
    assign w_bound_tgt = (halt_req || r_halt_pend) ? ST_HALT : ST_FETCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_halt_pend <= 1'b0;
            r_illegal   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op <= w_op_in;
            end
            if (w_boundary || w_idle_like) begin
                r_halt_pend <= 1'b0;
            end else if (halt_req) begin
                r_halt_pend <= 1'b1;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end else if ((r_state == ST_HALT) && start) begin
                r_illegal <= 1'b0;
            end
            if (w_retire) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_boundary = 1'b0;
        w_retire   = 1'b0;
        w_set_ill  = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_op_in == OP_HALT) begin
                    w_next   = ST_HALT;
                    w_retire = 1'b1;
                end else if (is_illegal(w_op_in)) begin
                    w_next    = ST_HALT;
                    w_set_ill = 1'b1;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_alu(r_op)) begin
                    w_next = ST_WB;
                end else if (is_mem(r_op)) begin
                    w_next = ST_MEM;
                end else begin
                    w_next     = w_bound_tgt;
                    w_boundary = 1'b1;
                    w_retire   = 1'b1;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (r_op == OP_STORE) begin
                        w_next     = w_bound_tgt;
                        w_boundary = 1'b1;
                        w_retire   = 1'b1;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_next     = w_bound_tgt;
                w_boundary = 1'b1;
                w_retire   = 1'b1;
            end
            default: w_next = ST_HALT;
        endcase
    end

    always_comb begin
        mem_req = (r_state == ST_FETCH) || (r_state == ST_MEM);
        mem_we  = (r_state == ST_MEM) && (r_op == OP_STORE);
        ir_we   = (r_state == ST_FETCH) && mem_ready;
        pc_we   = ((r_state == ST_FETCH) && mem_ready) ||
                  ((r_state == ST_EXEC) && is_flow(r_op));
        reg_we  = (r_state == ST_WB);
        busy    = !w_idle_like;
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, halt,
// illegal opcode, asynchronous reset and counter wrap.
module tb_multicycle_ctrl;

    localparam int OPW  = 4;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            halt_req;
    logic [OPW-1:0]  opcode;
    logic            mem_ready;
    logic [2:0]      state;
    logic            mem_req;
    logic            mem_we;
    logic            ir_we;
    logic            pc_we;
    logic            reg_we;
    logic            busy;
    logic            illegal;
    logic [CNTW-1:0] instr_count;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .opcode(opcode), .mem_ready(mem_ready), .state(state),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .busy(busy), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; opcode = 4'h0; mem_ready = 1'b1;
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_strobes", 32'({ir_we, pc_we, reg_we, mem_we}), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", 32'(state), 32'd0);

        // ALU op 0x3
        start = 1'b1; opcode = 4'h3;
        tick();
        start = 1'b0;
        chk("alu_fetch", 32'(state), 32'd1);
        chk("alu_fetch_str", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}), 32'b10110);
        chk("alu_busy", 32'(busy), 32'd1);
        tick();
        chk("alu_decode", 32'(state), 32'd2);
        chk("alu_dec_str", 32'({mem_req, ir_we, pc_we, reg_we}), 32'd0);
        tick();
        chk("alu_exec", 32'(state), 32'd3);
        chk("alu_exec_str", 32'({pc_we, reg_we}), 32'd0);
        tick();
        chk("alu_wb", 32'(state), 32'd5);
        chk("alu_wb_reg_we", 32'(reg_we), 32'd1);
        tick();
        chk("alu_done", 32'(state), 32'd1);
        chk("alu_reg_we_off", 32'(reg_we), 32'd0);
        chk("alu_count", 32'(instr_count), 32'd1);

        // load 0x8 with two wait states in MEM
        opcode = 4'h8;
        tick(); tick();
        chk("ld_exec", 32'(state), 32'd3);
        tick();
        chk("ld_mem1", 32'(state), 32'd4);
        chk("ld_mem1_str", 32'({mem_req, mem_we}), 32'b10);
        mem_ready = 1'b0;
        tick();
        chk("ld_mem2", 32'(state), 32'd4);
        tick();
        chk("ld_mem3", 32'(state), 32'd4);
        chk("ld_mem3_str", 32'({mem_req, mem_we, reg_we}), 32'b100);
        mem_ready = 1'b1;
        tick();
        chk("ld_wb", 32'(state), 32'd5);
        chk("ld_wb_reg_we", 32'(reg_we), 32'd1);
        tick();
        chk("ld_done", 32'(state), 32'd1);
        chk("ld_count", 32'(instr_count), 32'd2);

        // store 0x9
        opcode = 4'h9;
        tick(); tick();
        chk("st_exec_we", 32'(mem_we), 32'd0);
        tick();
        chk("st_mem", 32'(state), 32'd4);
        chk("st_mem_str", 32'({mem_req, mem_we, reg_we}), 32'b110);
        tick();
        chk("st_done", 32'(state), 32'd1);
        chk("st_we_off", 32'({mem_we, reg_we}), 32'd0);
        chk("st_count", 32'(instr_count), 32'd3);

        // branch 0xA
        opcode = 4'hA;
        chk("br_fetch_pc", 32'(pc_we), 32'd1);
        tick();
        chk("br_dec_pc", 32'(pc_we), 32'd0);
        tick();
        chk("br_exec", 32'(state), 32'd3);
        chk("br_exec_pc", 32'(pc_we), 32'd1);
        tick();
        chk("br_done", 32'(state), 32'd1);
        chk("br_count", 32'(instr_count), 32'd4);

        // halt_req pulsed in EXEC of ALU op
        opcode = 4'h2;
        tick(); tick();
        chk("hlt_exec", 32'(state), 32'd3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("hlt_wb", 32'(state), 32'd5);
        tick();
        chk("hlt_halt", 32'(state), 32'd6);
        chk("hlt_busy", 32'(busy), 32'd0);
        chk("hlt_count", 32'(instr_count), 32'd5);
        tick();
        chk("hlt_hold", 32'(state), 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hlt_restart", 32'(state), 32'd1);

        // halt opcode 0xF retires
        opcode = 4'hF;
        tick(); tick();
        chk("opf_halt", 32'(state), 32'd6);
        chk("opf_count", 32'(instr_count), 32'd6);
        chk("opf_illegal", 32'(illegal), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;

        // illegal 0xD
        opcode = 4'hD;
        tick(); tick();
        chk("ill_halt", 32'(state), 32'd6);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_count", 32'(instr_count), 32'd6);
        tick();
        chk("ill_sticky", 32'(illegal), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_clear", 32'(illegal), 32'd0);
        chk("ill_restart", 32'(state), 32'd1);

        // mem_ready outside FETCH/MEM ignored; reset mid-MEM
        opcode = 4'h8;
        tick(); tick(); tick();
        chk("rm_mem", 32'(state), 32'd4);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_state", 32'(state), 32'd0);
        chk("rm_mem_req", 32'(mem_req), 32'd0);
        chk("rm_count", 32'(instr_count), 32'd0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("rm_idle", 32'(state), 32'd0);

        // counter wrap: 255 jumps then one ALU op
        opcode = 4'hB;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick(); tick(); tick();
        end
        chk("wrap_pre", 32'(instr_count), 32'hFF);
        opcode = 4'h1;
        tick(); tick(); tick(); tick();
        chk("wrap_state", 32'(state), 32'd1);
        chk("wrap_count", 32'(instr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: OPW, default 4, opcode field width.
REQ-002 Parameter: CNTW, default 16, retired-instruction counter width.
REQ-003 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE/HALT and begin fetching
- halt_req  in  1  stop at next instruction boundary
- opcode  in  OPW  decoded instruction opcode, valid in DECODE
- mem_ready  in  1  memory accepted/completed current request
- state  out  3  current FSM state
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write (store) qualifier
- ir_we  out  1  instruction register load strobe
- pc_we  out  1  program counter update strobe
- reg_we  out  1  register file write strobe
- busy  out  1  state not IDLE and not HALT
- illegal  out  1  sticky illegal-opcode flag
- instr_count  out  CNTW  retired instructions

Function
REQ-004 State encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 SHALL go to HALT on the next clock.
REQ-005 IDLE and HALT SHALL go to FETCH on the first clock with start=1; otherwise they hold.
REQ-006 FETCH: mem_req=1, mem_we=0; on a clock with mem_ready=1, ir_we=1 and pc_we=1 for that cycle, next state DECODE; mem_ready=0 holds FETCH.
REQ-007 DECODE SHALL go to EXEC, except opcode 0xF goes to HALT (retired) and opcodes 0xC-0xE go to HALT with illegal set (not retired).
REQ-008 EXEC SHALL route by opcode: 0x0-0x7 (ALU) to WB; 0x8 (load) and 0x9 (store) to MEM; 0xA (branch) and 0xB (jump) to the boundary with pc_we=1 in EXEC.
REQ-009 MEM: mem_req=1, mem_we=1 only for store. Advancement on mem_ready=1: load to WB, store to the boundary; otherwise hold.
REQ-010 WB SHALL assert reg_we=1 for exactly one cycle, then go to the boundary.
REQ-011 Boundary: go to HALT if halt_req=1 on that clock, else FETCH; halt_req elsewhere SHALL NOT interrupt an instruction.
REQ-012 All strobes SHALL be Moore/registered-state decodes: one cycle wide, zero outside their state, never two strobes of the same name in consecutive cycles.
REQ-013 instr_count SHALL increment by 1 on each boundary transition and on DECODE->HALT for 0xF; it wraps from all-ones to 0.
REQ-014 illegal SHALL clear only on reset or on start while in HALT.
REQ-015 Latency: ALU 4 cycles, load 5, store 4, branch/jump 3, with zero wait states; each mem_ready=0 cycle adds one.
REQ-016 mem_ready asserted outside FETCH/MEM SHALL be ignored.

Reset
REQ-017 rst_n=0 SHALL immediately force: state=IDLE, every strobe=0, mem_req=0, illegal=0, instr_count=0, including mid-FETCH/MEM with a request pending.
REQ-018 After rst_n deasserts, the block SHALL remain in IDLE until start=1.

Structure
REQ-019 State codes, opcode constants and class ranges SHALL live in the shared processor package, used by the decoder and datapath.
REQ-020 Single module with no sub-module; next-state logic and output decode are separate from the state register.

Verification
REQ-021 Reset, start=1, opcode=0x3, mem_ready=1 -> states 1,2,3,5,1; reg_we high exactly in WB; instr_count=1.
REQ-022 Load 0x8 with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_req=1, mem_we=0, then WB; total 7 cycles.
REQ-023 Store 0x9 -> mem_we=1 only in MEM, no reg_we, back to FETCH; branch 0xA -> pc_we in FETCH and EXEC only.
REQ-024 halt_req pulsed during EXEC of ALU op -> WB completes, state=HALT, instr_count incremented; start -> FETCH.
REQ-025 opcode 0xD -> HALT, illegal=1, count unchanged; rst_n low mid-MEM -> IDLE, mem_req=0 with no clock edge.
REQ-026 Preload 0xFFFF retired then one ALU op -> instr_count=0.
